// File: rtl/mac_pkg.sv
// Shared types and constants for the mac_pipe multiply-accumulate pipeline.
package mac_pkg;
    typedef enum logic [1:0] {
        MULADD = 2'b00,
        ACC    = 2'b01,
        MULSUB = 2'b10,
        RSVD   = 2'b11
    } mac_mode_e;

    localparam int ACC_MARGIN = 4;
endpackage

// File: rtl/par_parameter.sv
// Project-wide base parameter; mac_pipe derives its operand width W as par + 1.
package par_parameter;
    localparam int par = 7;
endpackage

// File: rtl/mac_pipe_reg.sv
// One pipeline stage: enable-gated data register with a valid bit and async active-low clear.
module mac_pipe_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             valid_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o
);
    logic             valid_q;
    logic [WIDTH-1:0] data_q;

    // Stage contents advance only when the pipeline is enabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (en) begin
            valid_q <= valid_i;
            data_q  <= data_i;
        end else begin
            valid_q <= valid_q;
            data_q  <= data_q;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
endmodule

// File: rtl/mac_pipe.sv
// Two-stage multiply / multiply-add / multiply-sub / accumulate pipeline with valid-ready flow control.
// Build option: define MAC_SAT_EN to clamp out-of-range results instead of wrapping.
module mac_pipe
    import mac_pkg::*;
#(
    parameter int W     = par_parameter::par + 1,
    parameter int ACC_W = 2 * W + ACC_MARGIN
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     A,
    input  logic [W-1:0]     B,
    input  logic [W-1:0]     C,
    input  logic [1:0]       mode,
    input  logic             first,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] DATA_OUT,
    output logic             ovf
);
    localparam int S1_W = 3 * W + 3;
    // Two spare bits keep the exact result plus a sign bit for the subtract case.
    localparam int EW   = ACC_W + 2;

    logic              en_s;
    logic [2*W-1:0]    prod_s;
    logic [S1_W-1:0]   s1_data_s;
    logic              s1_valid_s;
    logic [2*W-1:0]    s1_p_s;
    logic [W-1:0]      s1_c_s;
    mac_mode_e         s1_mode_s;
    logic              s1_first_s;
    logic [EW-1:0]     exact_s;
    logic              neg_s;
    logic              over_s;
    logic              rsvd_s;
    logic              acc_sel_s;
    logic [ACC_W-1:0]  res_s;
    logic              ovf_s;
    logic [ACC_W:0]    s2_data_s;
    logic [ACC_W-1:0]  acc_q;
    logic [ACC_W-1:0]  acc_d;

    assign en_s     = !out_valid || out_ready;
    assign in_ready = en_s;
    assign prod_s   = A * B;

    mac_pipe_reg #(.WIDTH(S1_W)) u_stage1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en_s),
        .valid_i (in_valid),
        .data_i  ({first, mode, C, prod_s}),
        .valid_o (s1_valid_s),
        .data_o  (s1_data_s)
    );

    assign s1_p_s     = s1_data_s[2*W-1:0];
    assign s1_c_s     = s1_data_s[3*W-1:2*W];
    assign s1_mode_s  = mac_mode_e'(s1_data_s[3*W+1:3*W]);
    assign s1_first_s = s1_data_s[3*W+2];

    // Exact result in EW bits, then range classification and wrap/clamp.
    always_comb begin
        rsvd_s    = 1'b0;
        acc_sel_s = 1'b0;
        case (s1_mode_s)
            MULADD: exact_s = {{(EW-2*W){1'b0}}, s1_p_s} + {{(EW-W){1'b0}}, s1_c_s};
            ACC: begin
                exact_s   = (s1_first_s ? {EW{1'b0}} : {2'b00, acc_q}) + {{(EW-2*W){1'b0}}, s1_p_s};
                acc_sel_s = 1'b1;
            end
            MULSUB: exact_s = {{(EW-2*W){1'b0}}, s1_p_s} - {{(EW-W){1'b0}}, s1_c_s};
            default: begin
                exact_s = {{(EW-2*W){1'b0}}, s1_p_s} + {{(EW-W){1'b0}}, s1_c_s};
                rsvd_s  = 1'b1;
            end
        endcase
        neg_s  = exact_s[EW-1];
        over_s = !exact_s[EW-1] && exact_s[ACC_W];
        ovf_s  = neg_s || over_s || rsvd_s;
`ifdef MAC_SAT_EN
        if (neg_s) begin
            res_s = {ACC_W{1'b0}};
        end else if (over_s) begin
            res_s = {ACC_W{1'b1}};
        end else begin
            res_s = exact_s[ACC_W-1:0];
        end
`else
        res_s = exact_s[ACC_W-1:0];
`endif
    end

    mac_pipe_reg #(.WIDTH(ACC_W+1)) u_stage2 (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en_s),
        .valid_i (s1_valid_s),
        .data_i  ({ovf_s, res_s}),
        .valid_o (out_valid),
        .data_o  (s2_data_s)
    );

    assign DATA_OUT = s2_data_s[ACC_W-1:0];
    assign ovf      = s2_data_s[ACC_W];

    // The running sum commits only when an ACC result enters stage 2.
    always_comb begin
        if (en_s && s1_valid_s && acc_sel_s) begin
            acc_d = res_s;
        end else begin
            acc_d = acc_q;
        end
    end

    // Accumulator register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= {ACC_W{1'b0}};
        end else begin
            acc_q <= acc_d;
        end
    end
endmodule

// File: tb/tb_mac_pipe.sv
// Scoreboard bench for mac_pipe (W=8, ACC_W=20); expectations follow MAC_SAT_EN when defined.
module tb_mac_pipe;
    localparam int W     = 8;
    localparam int ACC_W = 20;
    localparam longint MAXV = (64'sd1 <<< ACC_W) - 64'sd1;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     A, B, C;
    logic [1:0]       mode;
    logic             first;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] DATA_OUT;
    logic             ovf;

    mac_pipe #(.W(W), .ACC_W(ACC_W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .C(C), .mode(mode), .first(first),
        .out_valid(out_valid), .out_ready(out_ready), .DATA_OUT(DATA_OUT), .ovf(ovf)
    );

    int n_cmp = 0;
    int n_err = 0;
    logic [ACC_W:0] exp_q[$];
    longint acc_m = 0;
    bit rand_ready = 1'b0;
    bit forced_ready = 1'b1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: exact integer result, then range rules.
    function automatic logic [ACC_W:0] model(input logic [1:0] m, input logic f,
                                             input longint a, input longint b, input longint c);
        longint p, ex, v;
        logic o;
        p = a * b;
        case (m)
            2'd1:    ex = (f ? 64'sd0 : acc_m) + p;
            2'd2:    ex = p - c;
            default: ex = p + c;
        endcase
        o = (ex < 0) || (ex > MAXV) || (m == 2'd3);
`ifdef MAC_SAT_EN
        v = (ex < 0) ? 64'sd0 : ((ex > MAXV) ? MAXV : ex);
`else
        v = ex & MAXV;
`endif
        if (m == 2'd1) acc_m = v;
        return {o, v[ACC_W-1:0]};
    endfunction

    always @(posedge clk) begin
        #1;
        out_ready = rand_ready ? 1'($urandom_range(0, 1)) : forced_ready;
    end

    // Monitor: every output transfer pops one expected result.
    always @(negedge clk) begin
        logic [ACC_W:0] e;
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_output: got %0d expected none", DATA_OUT);
            end else begin
                e = exp_q.pop_front();
                check("result", {ovf, DATA_OUT}, e);
            end
        end
    end

    task automatic send(input logic [1:0] m, input logic f, input logic [7:0] a,
                        input logic [7:0] b, input logic [7:0] c);
        bit done;
        @(posedge clk);
        #1;
        in_valid = 1'b1; mode = m; first = f; A = a; B = b; C = c;
        done = 1'b0;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back(model(m, f, a, b, c));
                done = 1'b1;
                break;
            end
        end
        if (!done) begin
            n_cmp++;
            n_err++;
            $display("FAIL accept_timeout: got in_ready 0 expected 1");
        end
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("drain_left", exp_q.size(), 0);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; A = 8'd0; B = 8'd0; C = 8'd0;
        mode = 2'd0; first = 1'b0; out_ready = 1'b1;
        #12;
        check("rst_out_valid", out_valid, 0);
        check("rst_data", DATA_OUT, 0);
        check("rst_ovf", ovf, 0);
        rst_n = 1'b1;
        check("rst_in_ready", in_ready, 1);

        // Basic MULADD with latency check.
        send(2'd0, 1'b0, 8'd3, 8'd4, 8'd5);
        idle();
        @(negedge clk);
        check("lat_edge1_valid", out_valid, 0);
        @(negedge clk);
        check("lat_edge2_valid", out_valid, 1);
        check("muladd_17", {ovf, DATA_OUT}, 17);
        drain();

        // Back-to-back accumulation.
        send(2'd1, 1'b1, 8'd2, 8'd3, 8'd0);
        send(2'd1, 1'b0, 8'd4, 8'd5, 8'd0);
        idle();
        drain();

        // MULSUB underflow.
        send(2'd2, 1'b0, 8'd2, 8'd2, 8'd10);
        idle();
        drain();

        // Backpressure: two accepted then stall.
        forced_ready = 1'b0;
        @(posedge clk);
        send(2'd0, 1'b0, 8'd10, 8'd11, 8'd1);
        send(2'd2, 1'b0, 8'd20, 8'd3, 8'd7);
        @(posedge clk);
        #1;
        in_valid = 1'b1; mode = 2'd0; A = 8'd1; B = 8'd2; C = 8'd3;
        @(negedge clk);
        check("stall_in_ready", in_ready, 0);
        check("stall_out_valid", out_valid, 1);
        forced_ready = 1'b1;
        send(2'd0, 1'b0, 8'd1, 8'd2, 8'd3);
        idle();
        drain();

        // Accumulation across the overflow boundary.
        send(2'd1, 1'b1, 8'd255, 8'd255, 8'd0);
        for (int i = 1; i < 17; i++) send(2'd1, 1'b0, 8'd255, 8'd255, 8'd0);
        idle();
        drain();
        check("acc17_model", acc_m,
`ifdef MAC_SAT_EN
              1048575
`else
              56849
`endif
        );

        // Reserved mode.
        send(2'd3, 1'b0, 8'd7, 8'd7, 8'd1);
        idle();
        drain();

        // Reset with two sets in flight.
        forced_ready = 1'b0;
        @(posedge clk);
        send(2'd1, 1'b0, 8'd9, 8'd9, 8'd0);
        send(2'd1, 1'b0, 8'd8, 8'd8, 8'd0);
        idle();
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", out_valid, 0);
        check("async_rst_data", DATA_OUT, 0);
        exp_q.delete();
        acc_m = 0;
        #2;
        rst_n = 1'b1;
        forced_ready = 1'b1;
        send(2'd1, 1'b0, 8'd1, 8'd1, 8'd0);
        idle();
        drain();

        // Randomized traffic with random backpressure.
        rand_ready = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) idle();
            else send(2'($urandom_range(0, 3)), 1'($urandom_range(0, 4) == 0),
                      8'($urandom), 8'($urandom), 8'($urandom));
        end
        idle();
        rand_ready = 1'b0;
        forced_ready = 1'b1;
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
